sar_threshold_search: RTL

- Successive-approximation controller that drives the threshold input (compare_B) of the registered comparator and consumes its 1-bit decision (compare_out).
- Binary-searches the largest code T with signal >= T; for an in-range DATA_WIDTH-bit input, T equals the input value.
- Sits beside the comparator in the detector datapath; turns the comparator into a DATA_WIDTH-bit digitiser / threshold finder.

---
 rtl/sar_threshold_search.sv | 95 +++++++++
 1 files changed

// File: rtl/sar_threshold_search.sv
// sar_threshold_search: successive-approximation threshold search driving a registered comparator; optional 2-of-3 vote per bit under SAR_MAJORITY_EN
module sar_threshold_search #(
  parameter int DATA_WIDTH  = 14,
  parameter int CMP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cmp_in,
  output logic [DATA_WIDTH-1:0] trial_code,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [3:0] LAT  = 4'(CMP_LATENCY);
  localparam logic [DATA_WIDTH-1:0] TOP = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] code, mask, new_code;
  logic [3:0]            cnt;
  logic                  decision, take;

`ifdef SAR_MAJORITY_EN
  logic [1:0] vidx;
  logic       v0, v1;
  assign decision = (v0 & v1) | (v0 & cmp_in) | (v1 & cmp_in);
  assign take     = (cnt == 4'd0) && (vidx == 2'd2);
  // collect the first two votes of a bit; a cancelled search drops its partial vote
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vidx <= 2'd0;
      v0   <= 1'b0;
      v1   <= 1'b0;
    end else if (state == IDLE || abort) begin
      vidx <= 2'd0;
    end else if (cnt == 4'd0) begin
      vidx <= (vidx == 2'd2) ? 2'd0 : vidx + 2'd1;
      if (vidx == 2'd0) v0 <= cmp_in;
      if (vidx == 2'd1) v1 <= cmp_in;
    end
`else
  assign decision = cmp_in;
  assign take     = (cnt == 4'd0);
`endif

  // comparator says signal >= trial when it reports 0, so the trial bit is kept
  assign new_code = decision ? code : (code | mask);

  // search sequencer: one mask bit resolved per comparator settle window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      code       <= '0;
      mask       <= '0;
      cnt        <= 4'd0;
      trial_code <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          code       <= '0;
          mask       <= TOP;
          trial_code <= TOP;
          cnt        <= LAT;
          busy       <= 1'b1;
          state      <= WAIT;
        end
      end else if (abort) begin
        trial_code <= result;
        busy       <= 1'b0;
        state      <= IDLE;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (take) begin
        code <= new_code;
        if (mask[0]) begin
          result     <= new_code;
          trial_code <= new_code;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end else begin
          mask       <= mask >> 1;
          trial_code <= new_code | (mask >> 1);
          cnt        <= LAT;
        end
      end
    end
endmodule
